// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared defaults and helper types for the fifo_buffer block:
//               default word/pointer widths, almost-full/empty thresholds,
//               the per-cycle operation encoding and the status-flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_DATA_SIZE    = 10;
    localparam int c_ADDR_SIZE    = 3;
    localparam int c_ALMOST_FULL  = 6;
    localparam int c_ALMOST_EMPTY = 2;

    // Accepted operation in a cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // All status flags are pure functions of the stored word count
    function automatic fifo_flags_t fifo_flags(input int count, input int depth,
                                               input int af_level, input int ae_level);
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.almost_full  = (count >= af_level);
        f.almost_empty = (count <= ae_level);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer_if
// Description : Push/pop handshake and status bundle of fifo_buffer.
//               master = producer/consumer side, slave = the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_buffer_if #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_SIZE-1:0] data_in;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr_en, rd_en, data_in,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data_in,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               fifo_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port storage for fifo_buffer. Synchronous write,
//               synchronous 1-cycle registered read. Only the read register is
//               reset; the array itself is never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = c_DATA_SIZE,
    parameter int ADDR_SIZE = c_ADDR_SIZE
) (
    input  wire                  clk,
    input  wire                  reset,
    input  wire                  i_wr_en,
    input  wire [ADDR_SIZE-1:0]  i_wr_addr,
    input  wire [DATA_SIZE-1:0]  i_wr_data,
    input  wire                  i_rd_en,
    input  wire [ADDR_SIZE-1:0]  i_rd_addr,
    output logic [DATA_SIZE-1:0] o_rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] r_mem [c_DEPTH];

    // Write port: store the word on an accepted push
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: register the addressed word on an accepted pop, hold otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer
// Description : Synchronous FIFO with registered pop data, occupancy count,
//               full/empty/almost flags and sticky overflow/underflow flags.
//               Storage lives in fifo_ram; pointers, count, flags and error
//               tracking live here. reset is synchronous, active-low.
//               Optional: define FIFO_BUFFER_ERR_EN to build overflow/underflow
//               detection; otherwise both outputs are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE    = c_DATA_SIZE,
    parameter int ADDR_SIZE    = c_ADDR_SIZE,
    parameter int ALMOST_FULL  = c_ALMOST_FULL,
    parameter int ALMOST_EMPTY = c_ALMOST_EMPTY
) (
    input  wire          clk,
    input  wire          reset,
    fifo_buffer_if.slave bus
);

    localparam int                 c_DEPTH     = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] c_COUNT_ONE = 1;
    localparam logic [ADDR_SIZE-1:0] c_PTR_ONE = 1;

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic [ADDR_SIZE:0]   w_count_next;
    fifo_flags_t          r_flags;
    fifo_flags_t          w_flags_next;
    logic                 r_valid;
    logic                 w_push;
    logic                 w_pop;
    fifo_op_t             w_op;

    // Accepted requests: gated by reset and by the registered full/empty flags
    assign w_push = reset && bus.wr_en && !r_flags.full;
    assign w_pop  = reset && bus.rd_en && !r_flags.empty;
    assign w_op   = fifo_op_t'({w_push, w_pop});

    // Next occupancy and the flags that follow from it
    always_comb begin
        w_count_next = r_count;
        case (w_op)
            OP_PUSH: w_count_next = r_count + c_COUNT_ONE;
            OP_POP:  w_count_next = r_count - c_COUNT_ONE;
            default: w_count_next = r_count;
        endcase
        w_flags_next = fifo_flags(int'(w_count_next), c_DEPTH, ALMOST_FULL, ALMOST_EMPTY);
    end

    // Pointer, count, flag and valid registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flags  <= fifo_flags(0, c_DEPTH, ALMOST_FULL, ALMOST_EMPTY);
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            r_flags <= w_flags_next;
            r_valid <= w_pop;
        end
    end

    fifo_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (bus.data_out)
    );

`ifdef FIFO_BUFFER_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: any request against full/empty sets them until reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && r_flags.full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && r_flags.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.valid_out    = r_valid;
    assign bus.fifo_count   = r_count;
    assign bus.full         = r_flags.full;
    assign bus.empty        = r_flags.empty;
    assign bus.almost_full  = r_flags.almost_full;
    assign bus.almost_empty = r_flags.almost_empty;

endmodule
`default_nettype wire
